stable_sample_filter: RTL and testbench
=======================================

# stable_sample_filter

Consumes the N-bit word produced by the two-flop input synchronizer and turns it into clean, handshaked samples for the motion-detection datapath. A word is emitted only after it has held steady for STABLE_CYCLES consecutive clocks, which rejects multi-bit skew and capture glitches. Each emitted word carries the absolute difference from the last accepted word and a motion flag set by comparing that difference against a runtime threshold.

## Interface
- N, 16, data width; must match the synchronizer width.
- STABLE_CYCLES, 4, consecutive matching cycles required to declare a word settled; ≥1.
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- d  in  N  synchronized input word, direct from the synchronizer output.
- thresh  in  N  unsigned motion threshold; sampled on the settle event.
- out_ready  in  1  downstream accepts the presented sample.
- out_valid  out  1  sample presented.
- out_data  out  N  settled word.
- delta  out  N  |out_data − last accepted word|.
- motion  out  1  delta > thresh (strict).
- overrun  out  1  one-cycle pulse when a settle event is dropped.

## Operation
- d_prev <= d every cycle. match = (d == d_prev).
- Counter cnt, width clog2(STABLE_CYCLES+1):
  - !match: cnt <= 0.
  - match and cnt < STABLE_CYCLES: cnt <= cnt+1.
  - Otherwise saturate.
- settle = match && cnt == STABLE_CYCLES−1. This gives exactly one event per stable episode.
- Registers last_word (N) and have_last (1). Both are 0 after reset.
- FSM has two states, S_SETTLE and S_PRESENT:
  - S_SETTLE, settle, and (!have_last or d != last_word):
    - latch out_data=d;
    - delta = have_last ? abs(d−last_word) : 0;
    - motion = have_last && delta>thresh;
    - go to S_PRESENT.
  - S_SETTLE, settle, and d == last_word: no output (input glitched back to the same value). Stay.
  - S_PRESENT: out_valid=1. out_data, delta and motion are held stable.
  - S_PRESENT and out_ready: last_word<=out_data, have_last<=1, go to S_SETTLE.
  - S_PRESENT and settle (with or without out_ready the same cycle): event dropped, overrun=1 for that cycle. Counting continues regardless of state.
- abs difference: subtract the smaller from the larger, unsigned. The N-bit result cannot overflow.
- Reset, at any time including mid-presentation:
  - out_valid=0, out_data=0, delta=0, motion=0, overrun=0;
  - FSM=S_SETTLE, cnt=0, d_prev=0, last_word=0, have_last=0.
- After reset with d held at 0, the first settle emits 0 with motion=0. The first sample is always presented.

## Timing
- d changes to W, first visible in cycle k:
  - cycle k: mismatch, cnt<=0;
  - cycle k+STABLE_CYCLES: settle;
  - cycle k+STABLE_CYCLES+1: out_valid=1.
- Latency is STABLE_CYCLES+1 clocks.
- Any change of d before settle restarts the count from the cycle of that change.
- Handshake is a transfer on out_valid && out_ready. out_valid drops the cycle after the transfer.
- out_valid never deasserts without a transfer. Outputs do not change while out_valid=1.
- Minimum spacing between two valid samples is STABLE_CYCLES+1 cycles after the input changes.
- overrun is combinational from registered state plus match, or registered one cycle later. Decided: registered, so it asserts in cycle settle+1.

## Structure
- Shared package mmd_pkg holds:
  - the FSM state encoding localparams (S_SETTLE=0, S_PRESENT=1);
  - the clog2 function used for the cnt width.
- One sub-module, stable_cnt: d_prev register, match compare, saturating counter, settle output. It is parameterized by N and STABLE_CYCLES.
- FSM, abs-diff and output registers live in the top.

## Test plan
- Reset release, d=0 held, out_ready=1, STABLE_CYCLES=4: valid from the 5th post-reset cycle. out_data=0, delta=0, motion=0; exactly one transfer.
- Sample sequence:
  - after accepting 0x0100, d=0x0180 held, thresh=0x0040: out_data=0x0180, delta=0x0080, motion=1.
  - then d=0x0170, thresh=0x0040: delta=0x0010, motion=0.
  - d=0x0100 after 0x0180 accepted: delta=0x0080. This checks the swapped-operand abs.
- Glitch rejection: d toggles 0x1234→0x1235 for 3 cycles, then back to 0x1234 (last accepted). No out_valid, no overrun.
- Backpressure: out_ready=0 while d moves to a new stable word. The first sample is held unchanged and overrun pulses once. After out_ready=1 a single transfer occurs and last_word equals the held sample.
- Reset mid-presentation: assert rst_n=0 while out_valid=1. All outputs are 0 immediately. After release the first settled word has motion=0 (have_last cleared).
- STABLE_CYCLES=1: a one-cycle-stable word settles. Latency is 2 cycles.

Source files
------------

// File: rtl/mmd_pkg.sv
// Shared definitions for the motion-detect front end: FSM state encoding and a
// constant-foldable clog2 for sizing counters from parameters.
package mmd_pkg;

  typedef enum logic {
    S_SETTLE  = 1'b0,
    S_PRESENT = 1'b1
  } state_e;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/stable_cnt.sv
// Stability detector: settle_o pulses once when d_i has matched its previous value
// for STABLE_CYCLES consecutive clocks; the counter saturates so an episode fires once.
module stable_cnt
  import mmd_pkg::*;
#(
  parameter int N             = 16,
  parameter int STABLE_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] d_i,
  output logic         settle_o
);

  localparam int            CW         = clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX    = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_SETTLE = CW'(STABLE_CYCLES - 1);

  logic [N-1:0]  d_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          match;

  always_comb begin
    match = (d_i == d_prev_q);
    cnt_d = cnt_q;
    if (!match) begin
      cnt_d = '0;
    end else if (cnt_q < CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign settle_o = match && (cnt_q == CNT_SETTLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_prev_q <= '0;
      cnt_q    <= '0;
    end else begin
      d_prev_q <= d_i;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/stable_sample_filter.sv
// Emits a settled input word with |delta| to the last accepted word and a motion flag;
// latency STABLE_CYCLES+1, outputs held under backpressure, dropped settles flag overrun.
module stable_sample_filter
  import mmd_pkg::*;
#(
  parameter int N             = 16,
  parameter int STABLE_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] d,
  input  logic [N-1:0] thresh,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [N-1:0] out_data,
  output logic [N-1:0] delta,
  output logic         motion,
  output logic         overrun
);

  state_e       state_q, state_d;
  logic [N-1:0] out_data_q, out_data_d;
  logic [N-1:0] delta_q, delta_d;
  logic         motion_q, motion_d;
  logic         overrun_q, overrun_d;
  logic [N-1:0] last_word_q, last_word_d;
  logic         have_last_q, have_last_d;
  logic         settle;
  logic         new_word;
  logic [N-1:0] abs_diff;

  stable_cnt #(
    .N             (N),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_stable_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .d_i      (d),
    .settle_o (settle)
  );

  always_comb begin
    abs_diff    = (d >= last_word_q) ? (d - last_word_q) : (last_word_q - d);
    // A settle that returns to the last accepted word is a glitch that came back.
    new_word    = settle && (!have_last_q || (d != last_word_q));
    state_d     = state_q;
    out_data_d  = out_data_q;
    delta_d     = delta_q;
    motion_d    = motion_q;
    overrun_d   = 1'b0;
    last_word_d = last_word_q;
    have_last_d = have_last_q;
    case (state_q)
      S_SETTLE: begin
        if (new_word) begin
          out_data_d = d;
          delta_d    = have_last_q ? abs_diff : '0;
          motion_d   = have_last_q && (abs_diff > thresh);
          state_d    = S_PRESENT;
        end
      end
      S_PRESENT: begin
        overrun_d = settle;
        if (out_ready) begin
          last_word_d = out_data_q;
          have_last_d = 1'b1;
          state_d     = S_SETTLE;
        end
      end
      default: state_d = S_SETTLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_SETTLE;
      out_data_q  <= '0;
      delta_q     <= '0;
      motion_q    <= 1'b0;
      overrun_q   <= 1'b0;
      last_word_q <= '0;
      have_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      delta_q     <= delta_d;
      motion_q    <= motion_d;
      overrun_q   <= overrun_d;
      last_word_q <= last_word_d;
      have_last_q <= have_last_d;
    end
  end

  assign out_valid = (state_q == S_PRESENT);
  assign out_data  = out_data_q;
  assign delta     = delta_q;
  assign motion    = motion_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_stable_sample_filter.sv
// Directed bench for stable_sample_filter: main instance with STABLE_CYCLES=4 and a
// second instance with STABLE_CYCLES=1 for the minimum-latency case.
module tb_stable_sample_filter;

  localparam int SC = 4;

  typedef struct {
    logic [15:0] w;
    logic [15:0] th;
    logic [15:0] e_data;
    logic [15:0] e_delta;
    logic        e_motion;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] d, thresh, out_data, delta;
  logic        out_ready, out_valid, motion, overrun;
  logic [15:0] d1, thresh1, out_data1, delta1;
  logic        out_ready1, out_valid1, motion1, overrun1;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_xfer = 0;
  int n_ovr  = 0;

  stable_sample_filter #(.N(16), .STABLE_CYCLES(SC)) dut (
    .clk(clk), .rst_n(rst_n), .d(d), .thresh(thresh), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .delta(delta), .motion(motion),
    .overrun(overrun)
  );

  stable_sample_filter #(.N(16), .STABLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .d(d1), .thresh(thresh1), .out_ready(out_ready1),
    .out_valid(out_valid1), .out_data(out_data1), .delta(delta1), .motion(motion1),
    .overrun(overrun1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (out_valid && out_ready) n_xfer++;
    if (overrun) n_ovr++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic run_sample(input vec_t v, input string tag);
    int lat;
    @(posedge clk);
    #1;
    d      = v.w;
    thresh = v.th;
    wait_valid(lat);
    check({tag, "_latency"}, 32'(lat), 32'(SC + 1));
    check({tag, "_data"},    32'(out_data), 32'(v.e_data));
    check({tag, "_delta"},   32'(delta),    32'(v.e_delta));
    check({tag, "_motion"},  32'(motion),   32'(v.e_motion));
    @(posedge clk);
    @(negedge clk);
    check({tag, "_valid_drop"}, 32'(out_valid), 32'(0));
  endtask

  initial begin
    vec_t vecs[8];
    int   lat, x0, o0, vcnt;
    bit   bad_hold, bad_ovr;

    vecs[0] = '{16'h0100, 16'h0040, 16'h0100, 16'h0100, 1'b1};
    vecs[1] = '{16'h0180, 16'h0040, 16'h0180, 16'h0080, 1'b1};
    vecs[2] = '{16'h0170, 16'h0040, 16'h0170, 16'h0010, 1'b0};
    vecs[3] = '{16'h0180, 16'h0010, 16'h0180, 16'h0010, 1'b0};
    vecs[4] = '{16'h0100, 16'h007F, 16'h0100, 16'h0080, 1'b1};
    vecs[5] = '{16'h0000, 16'hFFFF, 16'h0000, 16'h0100, 1'b0};
    vecs[6] = '{16'hFFFF, 16'hFFFE, 16'hFFFF, 16'hFFFF, 1'b1};
    vecs[7] = '{16'h0001, 16'h0000, 16'h0001, 16'hFFFE, 1'b1};

    rst_n = 1'b0; d = '0; thresh = '0; out_ready = 1'b1;
    d1 = '0; thresh1 = '0; out_ready1 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid",   32'(out_valid), 32'(0));
    check("rst_data",    32'(out_data),  32'(0));
    check("rst_delta",   32'(delta),     32'(0));
    check("rst_motion",  32'(motion),    32'(0));
    check("rst_overrun", 32'(overrun),   32'(0));

    // First sample after reset with d held at zero.
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    x0 = n_xfer;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("first_valid_c%0d", i), 32'(out_valid), 32'(i == SC));
      if (i == SC) begin
        check("first_data",   32'(out_data), 32'(0));
        check("first_delta",  32'(delta),    32'(0));
        check("first_motion", 32'(motion),   32'(0));
      end
    end
    repeat (15) @(posedge clk);
    @(negedge clk);
    check("first_one_xfer", 32'(n_xfer - x0), 32'(1));

    for (int k = 0; k < 8; k++) run_sample(vecs[k], $sformatf("vec%0d", k));

    // Glitch that returns to the last accepted word.
    run_sample('{16'h1234, 16'h0000, 16'h1234, 16'h1233, 1'b1}, "glitch_base");
    x0 = n_xfer; o0 = n_ovr; vcnt = 0;
    @(posedge clk);
    #1 d = 16'h1235;
    repeat (3) @(posedge clk);
    #1 d = 16'h1234;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid) vcnt++;
      @(posedge clk);
    end
    check("glitch_no_valid",   32'(vcnt),          32'(0));
    check("glitch_no_overrun", 32'(n_ovr - o0),    32'(0));

    // Backpressure: a second word settles while the first is held.
    @(posedge clk);
    #1;
    out_ready = 1'b0; d = 16'h2000; thresh = 16'h0100;
    wait_valid(lat);
    check("bp_latency", 32'(lat),      32'(SC + 1));
    check("bp_data",    32'(out_data), 32'(16'h2000));
    check("bp_delta",   32'(delta),    32'(16'h0DCC));
    check("bp_motion",  32'(motion),   32'(1));
    x0 = n_xfer; o0 = n_ovr; bad_hold = 1'b0; bad_ovr = 1'b0;
    d = 16'h3000;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (!out_valid || out_data !== 16'h2000 || delta !== 16'h0DCC || motion !== 1'b1)
        bad_hold = 1'b1;
      if (overrun !== (i == SC + 1)) bad_ovr = 1'b1;
    end
    check("bp_hold_stable",   32'(bad_hold),     32'(0));
    check("bp_overrun_cycle", 32'(bad_ovr),      32'(0));
    check("bp_overrun_once",  32'(n_ovr - o0),   32'(1));
    out_ready = 1'b1;
    repeat (6) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("bp_single_xfer", 32'(n_xfer - x0), 32'(1));
    check("bp_valid_low",   32'(out_valid),    32'(0));
    run_sample('{16'h2100, 16'h0100, 16'h2100, 16'h0100, 1'b0}, "bp_last_word");

    // Reset while a sample is being presented.
    @(posedge clk);
    #1;
    out_ready = 1'b0; d = 16'h4000; thresh = 16'h0000;
    wait_valid(lat);
    check("mid_pre_valid", 32'(out_valid), 32'(1));
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_valid",   32'(out_valid), 32'(0));
    check("mid_rst_data",    32'(out_data),  32'(0));
    check("mid_rst_delta",   32'(delta),     32'(0));
    check("mid_rst_motion",  32'(motion),    32'(0));
    check("mid_rst_overrun", 32'(overrun),   32'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1; out_ready = 1'b1;
    wait_valid(lat);
    check("mid_post_latency", 32'(lat),      32'(SC + 1));
    check("mid_post_data",    32'(out_data), 32'(16'h4000));
    check("mid_post_delta",   32'(delta),    32'(0));
    check("mid_post_motion",  32'(motion),   32'(0));

    // STABLE_CYCLES=1 instance: two-cycle latency, words stable for a single match.
    repeat (5) @(posedge clk);
    #1;
    d1 = 16'h00AA; thresh1 = 16'h0010;
    @(posedge clk);
    @(negedge clk);
    check("sc1_c1_valid", 32'(out_valid1), 32'(0));
    @(posedge clk);
    @(negedge clk);
    check("sc1_c2_valid", 32'(out_valid1), 32'(1));
    check("sc1_aa_data",  32'(out_data1),  32'(16'h00AA));
    check("sc1_aa_delta", 32'(delta1),     32'(16'h00AA));
    d1 = 16'h0055;
    @(posedge clk);
    @(negedge clk);
    check("sc1_55_gap", 32'(out_valid1), 32'(0));
    @(posedge clk);
    @(negedge clk);
    check("sc1_55_valid",  32'(out_valid1), 32'(1));
    check("sc1_55_data",   32'(out_data1),  32'(16'h0055));
    check("sc1_55_delta",  32'(delta1),     32'(16'h0055));
    check("sc1_55_motion", 32'(motion1),    32'(1));
    d1 = 16'h0066;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("sc1_66_valid",  32'(out_valid1), 32'(1));
    check("sc1_66_data",   32'(out_data1),  32'(16'h0066));
    check("sc1_66_delta",  32'(delta1),     32'(16'h0011));
    check("sc1_66_motion", 32'(motion1),    32'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
